fetch_unit: RTL and testbench

//  Instruction-fetch front end: owns the PC, requests words from instruction memory, buffers

---
 rtl/types_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : request-tracking FSM states
//   NOP_INSTR     : value shown on instr while the fetch buffer is empty
//   WORD_STEP     : byte increment between sequential fetch addresses
package types_pkg;

  // IDLE    : no imem request outstanding
  // WAIT    : one request outstanding, its response is on the correct path
  // DISCARD : one request outstanding, its response is wrong-path and dropped
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned WORD_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} entries.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i        : write push_data_i at the tail (caller guarantees not full)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the FIFO; wins over push and pop in the same cycle
//   push_data_i   : entry to write
//   count_o       : number of valid entries (0..DEPTH)
//   head_o        : oldest entry (stale contents when count_o == 0)
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i & ~flush_i;
  assign pop_ok  = pop_i & ~flush_i & (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one-at-a-time imem
// requests, buffers responses in fetch_fifo and presents {instr, instr_pc}
// to decode. A taken branch (PCsrc on a consumed instruction) redirects the
// PC, flushes the buffer and discards any in-flight wrong-path response.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   imem_req_valid/ready/addr      : request channel to instruction memory
//   imem_rsp_valid/data            : in-order response, one per accepted request
//   instr_valid/ready, instr, instr_pc : head of fetch buffer to decode
//   PCsrc, ImmOp                   : branch-taken flag and offset, used on consume
//   dbg_state                      : request FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once imem_req_valid rises, it and imem_req_addr stay unchanged
// until accepted, even across a redirect. instr_valid/instr/instr_pc depend
// only on registered state, never on instr_ready.
module fetch_unit
  import types_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FIFO_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output fetch_state_t          dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  stale_q, stale_d;
  logic                  run_q;

  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         fifo_head;
  logic                  redirect;
  logic                  req_fire;
  logic                  push;
  logic [ADDR_WIDTH-1:0] target;

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .pop_i       (instr_valid & instr_ready),
    .flush_i     (redirect),
    .push_data_i ({req_pc_q, imem_rsp_data}),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? fifo_head[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP_INSTR);
  assign instr_pc    = instr_valid ? fifo_head[FW-1:DATA_WIDTH] : '0;

  assign redirect = instr_valid & instr_ready & PCsrc;
  assign target   = (instr_pc + ADDR_WIDTH'($signed(ImmOp))) & ~ADDR_WIDTH'(3);

  // Requesting only in IDLE (nothing outstanding) with a free slot reserves
  // room for the response. run_q keeps valid low in the cycle reset is held.
  assign imem_req_valid = run_q & (state_q == IDLE) & (fifo_count < CW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign push           = imem_rsp_valid & (state_q == WAIT) & ~redirect;
  assign dbg_state      = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    tgt_d      = tgt_q;
    stale_d    = stale_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          req_pc_d = fetch_pc_q;
          if (redirect || stale_q) begin
            // The accepted address is wrong-path: discard its response and
            // restart from the newest branch target.
            state_d    = DISCARD;
            fetch_pc_d = redirect ? target : tgt_q;
            stale_d    = 1'b0;
          end else begin
            state_d    = WAIT;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(WORD_STEP);
          end
        end else if (redirect) begin
          if (imem_req_valid) begin
            // The pending request cannot be withdrawn, so park the target
            // until the old address is accepted.
            stale_d = 1'b1;
            tgt_d   = target;
          end else begin
            fetch_pc_d = target;
          end
        end
      end
      WAIT: begin
        // A response in the redirect cycle closes the request but is dropped.
        if (imem_rsp_valid) state_d = IDLE;
        else if (redirect)  state_d = DISCARD;
        if (redirect) fetch_pc_d = target;
      end
      DISCARD: begin
        if (imem_rsp_valid) state_d = IDLE;
        if (redirect) fetch_pc_d = target;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VECTOR;
      req_pc_q   <= '0;
      tgt_q      <= '0;
      stale_q    <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      tgt_q      <= tgt_d;
      stale_q    <= stale_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: instance u_dut uses the default reset
// vector, u_dut_rv starts at 0xFFFFFFFC for the address wrap and mid-run
// reset scenario. Inputs change on the falling edge; outputs are checked on
// the falling edge before new inputs are applied.
module tb_fetch_unit;
  import types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // u_dut signals
  logic         rst = 1'b1, req_ready = 1'b0, rsp_valid = 1'b0, instr_ready = 1'b0, pcsrc = 1'b0;
  logic [31:0]  rsp_data = '0, immop = '0;
  logic         req_valid, instr_valid;
  logic [31:0]  req_addr, instr, instr_pc;
  fetch_state_t state;

  // u_dut_rv signals
  logic         rst_b = 1'b1, req_ready_b = 1'b0, rsp_valid_b = 1'b0;
  logic [31:0]  rsp_data_b = '0;
  logic         req_valid_b, instr_valid_b;
  logic [31:0]  req_addr_b, instr_b, instr_pc_b;
  fetch_state_t state_b;

  fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .PCsrc(pcsrc), .ImmOp(immop), .dbg_state(state)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_rv (
    .clk(clk), .rst(rst_b),
    .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b), .imem_req_addr(req_addr_b),
    .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
    .instr_valid(instr_valid_b), .instr_ready(1'b0), .instr(instr_b), .instr_pc(instr_pc_b),
    .PCsrc(1'b0), .ImmOp(32'h0), .dbg_state(state_b)
  );

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0; immop = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Fetch n sequential words from base, popping the previous word on each
  // accepted request; ends with only the last word buffered.
  task automatic run_fetches(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      req_ready = 1'b1; instr_ready = 1'b1; rsp_valid = 1'b0;
      @(negedge clk);
      req_ready = 1'b0; instr_ready = 1'b0; rsp_valid = 1'b1; rsp_data = data_for(base + 32'(4 * i));
      @(negedge clk);
      rsp_valid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++; if (req_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    vec_cnt++; if (instr !== 32'h0000_0013) begin err_cnt++; $display("FAIL rst_instr: got %h want 00000013", instr); end
    vec_cnt++; if (instr_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    vec_cnt++; if (state !== IDLE) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", state); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(4 * k);
      vec_cnt++; if (req_valid !== 1'b1 || req_addr !== exp_pc) begin err_cnt++; $display("FAIL seq_req: got v=%b a=%h want v=1 a=%h", req_valid, req_addr, exp_pc); end
      if (k > 0) begin
        vec_cnt++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc - 4 || instr !== data_for(exp_pc - 4)) begin err_cnt++; $display("FAIL seq_instr: got v=%b pc=%h d=%h want pc=%h", instr_valid, instr_pc, instr, exp_pc - 4); end
      end
      req_ready = 1'b1; instr_ready = 1'b1; rsp_valid = 1'b0;
      @(negedge clk);
      vec_cnt++; if (req_valid !== 1'b0 || instr_valid !== 1'b0 || state !== WAIT) begin err_cnt++; $display("FAIL seq_wait: got v=%b iv=%b st=%0d want 0 0 1", req_valid, instr_valid, state); end
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = data_for(exp_pc);
      @(negedge clk);
      rsp_valid = 1'b0;
    end
    vec_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== data_for(32'h8)) begin err_cnt++; $display("FAIL seq_last: got v=%b pc=%h d=%h want pc=8", instr_valid, instr_pc, instr); end
    vec_cnt++; if (req_addr !== 32'hC) begin err_cnt++; $display("FAIL seq_next_addr: got %h want c", req_addr); end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_ready = 1'b1; @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = data_for(32'h0); @(negedge clk);
    rsp_valid = 1'b0;
    vec_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h4) begin err_cnt++; $display("FAIL bp_req1: got v=%b a=%h want v=1 a=4", req_valid, req_addr); end
    req_ready = 1'b1; @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = data_for(32'h4); @(negedge clk);
    rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (req_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_full_valid: got %b want 0", req_valid); end
      vec_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin err_cnt++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
      @(negedge clk);
    end
    instr_ready = 1'b1; @(negedge clk);
    instr_ready = 1'b0;
    vec_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8) begin err_cnt++; $display("FAIL bp_resume: got v=%b a=%h want v=1 a=8", req_valid, req_addr); end
    vec_cnt++; if (instr_pc !== 32'h4 || instr !== data_for(32'h4)) begin err_cnt++; $display("FAIL bp_head2: got pc=%h d=%h want pc=4", instr_pc, instr); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    run_fetches(32'h0, 5);
    vec_cnt++; if (instr_pc !== 32'h10 || req_addr !== 32'h14) begin err_cnt++; $display("FAIL rp_setup: got pc=%h a=%h want pc=10 a=14", instr_pc, req_addr); end
    req_ready = 1'b1; @(negedge clk);
    vec_cnt++; if (state !== WAIT) begin err_cnt++; $display("FAIL rp_wait: got %0d want 1", state); end
    req_ready = 1'b0; instr_ready = 1'b1; pcsrc = 1'b1; immop = 32'hFFFF_FFF8;
    @(negedge clk);
    vec_cnt++; if (instr_valid !== 1'b0 || state !== DISCARD || req_valid !== 1'b0) begin err_cnt++; $display("FAIL rp_flush: got iv=%b st=%0d rv=%b want 0 2 0", instr_valid, state, req_valid); end
    instr_ready = 1'b0; pcsrc = 1'b0; immop = '0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rsp_valid = 1'b0;
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL rp_dropped: got iv=%b want 0", instr_valid); end
    vec_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h8) begin err_cnt++; $display("FAIL rp_target: got v=%b a=%h want v=1 a=8", req_valid, req_addr); end
    run_fetches(32'h8, 1);
    vec_cnt++; if (instr_pc !== 32'h8 || instr !== data_for(32'h8)) begin err_cnt++; $display("FAIL rp_newpath: got pc=%h d=%h want pc=8", instr_pc, instr); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    run_fetches(32'h0, 1);
    req_ready = 1'b1; @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hBAD0_0004; instr_ready = 1'b1; pcsrc = 1'b1; immop = 32'h6;
    @(negedge clk);
    rsp_valid = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0; immop = '0;
    vec_cnt++; if (instr_valid !== 1'b0 || state !== IDLE) begin err_cnt++; $display("FAIL rs_drop: got iv=%b st=%0d want 0 0", instr_valid, state); end
    vec_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h4) begin err_cnt++; $display("FAIL rs_target: got v=%b a=%h want v=1 a=4", req_valid, req_addr); end
    run_fetches(32'h4, 1);
    vec_cnt++; if (instr_pc !== 32'h4 || instr !== data_for(32'h4)) begin err_cnt++; $display("FAIL rs_newpath: got pc=%h d=%h want pc=4", instr_pc, instr); end
    // old-address request accepted in the redirect cycle
    req_ready = 1'b1; instr_ready = 1'b1; pcsrc = 1'b1; immop = 32'h1C;
    @(negedge clk);
    req_ready = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0; immop = '0;
    vec_cnt++; if (state !== DISCARD || instr_valid !== 1'b0 || req_valid !== 1'b0) begin err_cnt++; $display("FAIL rs_hs_discard: got st=%0d iv=%b rv=%b want 2 0 0", state, instr_valid, req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_0008; @(negedge clk);
    rsp_valid = 1'b0;
    vec_cnt++; if (instr_valid !== 1'b0 || req_addr !== 32'h20 || req_valid !== 1'b1) begin err_cnt++; $display("FAIL rs_hs_target: got iv=%b v=%b a=%h want 0 1 20", instr_valid, req_valid, req_addr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin err_cnt++; $display("FAIL st_hold: got v=%b a=%h want v=1 a=0", req_valid, req_addr); end
      @(negedge clk);
    end
    run_fetches(32'h0, 1);
    pcsrc = 1'b1; immop = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || req_addr !== 32'h4) begin err_cnt++; $display("FAIL st_pcsrc_ignored: got iv=%b pc=%h a=%h want 1 0 4", instr_valid, instr_pc, req_addr); end
    end
    // redirect while the request is still waiting for ready
    immop = 32'h40; instr_ready = 1'b1; @(negedge clk);
    instr_ready = 1'b0; pcsrc = 1'b0; immop = '0;
    vec_cnt++; if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h4) begin err_cnt++; $display("FAIL st_no_retract: got iv=%b v=%b a=%h want 0 1 4", instr_valid, req_valid, req_addr); end
    req_ready = 1'b1; @(negedge clk);
    req_ready = 1'b0;
    vec_cnt++; if (state !== DISCARD) begin err_cnt++; $display("FAIL st_discard: got %0d want 2", state); end
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_0044; @(negedge clk);
    rsp_valid = 1'b0;
    vec_cnt++; if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h40) begin err_cnt++; $display("FAIL st_target: got iv=%b v=%b a=%h want 0 1 40", instr_valid, req_valid, req_addr); end
  endtask

  task automatic test_wrap_and_reset();
    rst_b = 1'b1; repeat (2) @(negedge clk);
    rst_b = 1'b0; @(negedge clk);
    vec_cnt++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL rv_first: got v=%b a=%h want v=1 a=fffffffc", req_valid_b, req_addr_b); end
    req_ready_b = 1'b1; @(negedge clk);
    req_ready_b = 1'b0; rsp_valid_b = 1'b1; rsp_data_b = 32'h1111_1111; @(negedge clk);
    rsp_valid_b = 1'b0;
    vec_cnt++; if (req_addr_b !== 32'h0 || instr_pc_b !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL rv_wrap: got a=%h pc=%h want a=0 pc=fffffffc", req_addr_b, instr_pc_b); end
    req_ready_b = 1'b1; @(negedge clk);
    req_ready_b = 1'b0;
    vec_cnt++; if (state_b !== WAIT) begin err_cnt++; $display("FAIL rv_wait: got %0d want 1", state_b); end
    rst_b = 1'b1; @(negedge clk);
    vec_cnt++; if (req_valid_b !== 1'b0 || instr_valid_b !== 1'b0 || instr_b !== 32'h0000_0013 || state_b !== IDLE) begin err_cnt++; $display("FAIL rv_midreset: got rv=%b iv=%b i=%h st=%0d", req_valid_b, instr_valid_b, instr_b, state_b); end
    rst_b = 1'b0; rsp_valid_b = 1'b1; rsp_data_b = 32'h2222_2222; @(negedge clk);
    rsp_valid_b = 1'b0;
    vec_cnt++; if (instr_valid_b !== 1'b0) begin err_cnt++; $display("FAIL rv_late_rsp: got iv=%b want 0", instr_valid_b); end
    vec_cnt++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL rv_restart: got v=%b a=%h want v=1 a=fffffffc", req_valid_b, req_addr_b); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_pending();
    test_redirect_same_cycle();
    test_req_stall();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
